mem_slice: RTL and testbench

MEM_SLICE -- requirements
Module: mem_slice

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/mem_ctrl.sv | 79 +++++++
 rtl/mem_slice.sv | 72 +++++++
 tb/tb_mem_slice.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-stage FSM states, control-field bit positions
// and the data-memory timeout limit.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

  localparam int unsigned WB_W        = 7;
  localparam int unsigned M_W         = 2;
  localparam int unsigned DATA_W      = 16;

  localparam int unsigned WB_REGWRITE = 6;
  localparam int unsigned WB_MEMTOREG = 5;
  localparam int unsigned WB_OPAQUE   = 4;
  localparam int unsigned WB_RD_MSB   = 3;
  localparam int unsigned WB_RD_LSB   = 0;

  localparam int unsigned M_READ      = 1;
  localparam int unsigned M_WRITE     = 0;

  localparam logic [7:0]  MEM_TIMEOUT = 8'd255;

endpackage

// File: rtl/mem_ctrl.sv
// Data-memory access sequencer: IDLE -> ACCESS -> DONE with a bounded wait
// counter, captured load data and a sticky timeout flag.
module mem_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [M_W-1:0]    m,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_err
);

  mem_state_t state;
  logic [7:0] wait_cnt;
  logic       served;

  // served marks the held instruction as already accessed, so a downstream
  // stall through DONE cannot restart the same access from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_req  <= 1'b0;
      rdata    <= '0;
      mem_err  <= 1'b0;
      served   <= 1'b0;
    end else begin
      if (load) served <= 1'b0;
      case (state)
        IDLE: begin
          if (m != '0 && !served) begin
            state    <= ACCESS;
            wait_cnt <= '0;
            mem_req  <= 1'b1;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state   <= DONE;
            mem_req <= 1'b0;
            served  <= 1'b1;
            if (!m[M_WRITE]) rdata <= mem_rdata;
          end else if (wait_cnt == MEM_TIMEOUT) begin
            state   <= DONE;
            mem_req <= 1'b0;
            served  <= 1'b1;
            mem_err <= 1'b1;
            if (!m[M_WRITE]) rdata <= '1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_stall = (state == ACCESS) || (state == IDLE && m != '0 && !served);
    mem_we    = mem_req & m[M_WRITE];
    mem_addr  = addr;
    mem_wdata = data;
  end

endmodule

// File: rtl/mem_slice.sv
// MEM pipeline stage: EX/MEM register with stall/flush, data-memory
// sequencer and the writeback data select.
module mem_slice
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [WB_W-1:0]   WB_in,
  input  logic [M_W-1:0]    M_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] result_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_stall,
  output logic [WB_W-1:0]   WB,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  logic [M_W-1:0]    m_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              load_en;

  assign load_en = !stall_in && !mem_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB     <= '0;
      m_q    <= '0;
      addr_q <= '0;
      data_q <= '0;
      result <= '0;
    end else if (load_en) begin
      WB     <= flush_in ? '0 : WB_in;
      m_q    <= flush_in ? '0 : M_in;
      addr_q <= addr_in;
      data_q <= data_in;
      result <= result_in;
    end
  end

  mem_ctrl u_mem_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_en),
    .m         (m_q),
    .addr      (addr_q),
    .data      (data_q),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_stall (mem_stall),
    .rdata     (rdata),
    .mem_err   (mem_err)
  );

  assign wb_data = WB[WB_MEMTOREG] ? rdata : result;

endmodule

// File: tb/tb_mem_slice.sv
// Scoreboard bench for mem_slice: a behavioural memory responder with a
// programmable wait count, expected stage results queued per instruction.
module tb_mem_slice;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [6:0]  WB_in = '0;
  logic [1:0]  M_in = '0;
  logic [15:0] addr_in = '0, data_in = '0, result_in = '0;
  logic        mem_req, mem_we, mem_stall, mem_err;
  logic [15:0] mem_addr, mem_wdata, result, rdata, wb_data;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [6:0]  WB;

  mem_slice dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .WB_in(WB_in), .M_in(M_in), .addr_in(addr_in), .data_in(data_in),
    .result_in(result_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_stall(mem_stall), .WB(WB), .result(result),
    .rdata(rdata), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  wb;
    logic [15:0] result;
    logic [15:0] rdata;
    logic [15:0] wb_data;
    logic        chk_data;
    logic        err;
    int          stall;
    int          req;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // wait_c < 0 means the memory never answers; hold keeps stall_in high
  // through the access and two cycles past it.
  task automatic run_instr(input logic [6:0] wb, input logic [1:0] m,
                           input logic [15:0] addr, input logic [15:0] data,
                           input logic [15:0] res, input logic flush,
                           input logic [15:0] rdv, input int wait_c,
                           input logic hold);
    exp_t e;
    exp_t got;
    logic is_mem, we, tmo, done;
    int   nstall, nreq;
    is_mem = (m != 2'b00) && !flush;
    we     = m[0];
    tmo    = (wait_c < 0) || (wait_c > 255);
    e.req  = is_mem ? (tmo ? 256 : wait_c + 1) : 0;
    e.stall = is_mem ? e.req + 1 : 0;
    if (is_mem && !we) exp_rdata = tmo ? 16'hFFFF : rdv;
    if (is_mem && tmo) exp_err = 1'b1;
    e.wb       = flush ? 7'h00 : wb;
    e.result   = res;
    e.rdata    = exp_rdata;
    e.err      = exp_err;
    e.wb_data  = e.wb[5] ? exp_rdata : res;
    e.chk_data = !flush;
    sb.push_back(e);

    WB_in = wb; M_in = m; addr_in = addr; data_in = data;
    result_in = res; flush_in = flush;
    @(posedge clk);
    #1;
    WB_in = '0; M_in = '0; flush_in = 1'b0;
    if (hold) stall_in = 1'b1;

    nstall = 0; nreq = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) nstall++;
      if (mem_req) begin
        nreq++;
        check_eq("mem_addr", {16'h0, mem_addr}, {16'h0, addr});
        check_eq("mem_we", {31'h0, mem_we}, {31'h0, we});
        if (we) check_eq("mem_wdata", {16'h0, mem_wdata}, {16'h0, data});
        mem_ready = !tmo && (nreq - 1 == wait_c);
        mem_rdata = mem_ready ? rdv : 16'h0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
      end
      if (!mem_stall) done = 1'b1;
    end
    if (!done) check_eq("stall_bound", 32'd0, 32'd1);

    got = sb.pop_front();
    check_eq("stall_cycles", nstall, got.stall);
    check_eq("req_cycles", nreq, got.req);
    check_eq("rdata", {16'h0, rdata}, {16'h0, got.rdata});
    check_eq("mem_err", {31'h0, mem_err}, {31'h0, got.err});
    check_eq("WB", {25'h0, WB}, {25'h0, got.wb});
    if (got.chk_data) begin
      check_eq("result", {16'h0, result}, {16'h0, got.result});
      check_eq("wb_data", {16'h0, wb_data}, {16'h0, got.wb_data});
    end

    if (hold) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        check_eq("hold_no_req", {31'h0, mem_req}, 32'd0);
        check_eq("hold_no_stall", {31'h0, mem_stall}, 32'd0);
      end
      stall_in = 1'b0;
    end
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    check_eq("rst_WB", {25'h0, WB}, 32'd0);
    check_eq("rst_result", {16'h0, result}, 32'd0);
    check_eq("rst_rdata", {16'h0, rdata}, 32'd0);
    check_eq("rst_req", {31'h0, mem_req}, 32'd0);
    check_eq("rst_stall", {31'h0, mem_stall}, 32'd0);
    check_eq("rst_err", {31'h0, mem_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // load, ready on first access cycle
    run_instr(7'b110_0101, 2'b10, 16'h0040, 16'h0000, 16'h0111, 1'b0, 16'hBEEF, 0, 1'b0);
    // store, three wait cycles, upstream stall held throughout
    run_instr(7'b000_0000, 2'b01, 16'h0010, 16'h1234, 16'h0222, 1'b0, 16'hDEAD, 3, 1'b1);
    // both control bits set acts as a write
    run_instr(7'b010_0011, 2'b11, 16'h0020, 16'h5678, 16'h0333, 1'b0, 16'hCAFE, 1, 1'b0);
    // back-to-back ALU ops
    run_instr(7'b100_0010, 2'b00, 16'h0000, 16'h0000, 16'h0007, 1'b0, 16'h0000, 0, 1'b0);
    run_instr(7'b101_0100, 2'b00, 16'h0000, 16'h0000, 16'h0099, 1'b0, 16'h0000, 0, 1'b0);
    // flushed load becomes a bubble
    run_instr(7'b110_0001, 2'b10, 16'h0044, 16'h0000, 16'h0444, 1'b1, 16'h1111, 0, 1'b0);
    // load with a different latency, MemToReg clear
    run_instr(7'b100_0110, 2'b10, 16'h0050, 16'h0000, 16'h0555, 1'b0, 16'h4242, 2, 1'b0);
    // memory never answers
    run_instr(7'b110_0111, 2'b10, 16'h0060, 16'h0000, 16'h0666, 1'b0, 16'h0000, -1, 1'b0);
    // error stays set across later traffic
    run_instr(7'b100_1000, 2'b00, 16'h0000, 16'h0000, 16'h0777, 1'b0, 16'h0000, 0, 1'b0);

    // reset in the middle of an access
    WB_in = 7'b110_1001; M_in = 2'b10; addr_in = 16'h0070;
    @(posedge clk);
    #1;
    WB_in = '0; M_in = '0;
    k = 0;
    while (!mem_req && k < 5) begin
      @(negedge clk);
      k++;
    end
    check_eq("reach_access", {31'h0, mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_req_drop", {31'h0, mem_req}, 32'd0);
    check_eq("async_stall_drop", {31'h0, mem_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0;
    exp_err = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("post_rst_WB", {25'h0, WB}, 32'd0);
      check_eq("post_rst_stall", {31'h0, mem_stall}, 32'd0);
      check_eq("post_rst_req", {31'h0, mem_req}, 32'd0);
      check_eq("post_rst_err", {31'h0, mem_err}, 32'd0);
    end
    // pipeline still works after reset
    run_instr(7'b110_0101, 2'b10, 16'h0080, 16'h0000, 16'h0888, 1'b0, 16'h7E57, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
